// File: rtl/parking_access_ctrl.sv
// Parking entry gate controller: PIN-qualified entry, entry timeout, tailgate
// blocking alarm and occupancy tracking with an exit-lane decrement.
module parking_access_ctrl #(
  parameter int              PW        = 8,
  parameter logic [PW-1:0]   PASSWORD  = 8'd87,
  parameter int              MAX_TRIES = 3,
  parameter int              CAPACITY  = 16,
  parameter int              TIMEOUT   = 1000,
  localparam int             OW        = $clog2(CAPACITY + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          car_arrive,
  input  logic          car_passed,
  input  logic          car_exit,
  input  logic          try_pin,
  input  logic [PW-1:0] pin,
  output logic          open_gate,
  output logic          close_gate,
  output logic          alarm_pin,
  output logic          alarm_block,
  output logic          lot_full,
  output logic [OW-1:0] occupancy
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int NW = $clog2(MAX_TRIES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PIN   = 2'd1,
    OPEN  = 2'd2,
    BLOCK = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [NW-1:0] tries, tries_next;
  logic [TW-1:0] timer, timer_next;
  logic [OW-1:0] occupancy_next;
  logic          open_gate_next, close_gate_next, alarm_pin_next, alarm_block_next;

  logic pin_ok, pin_bad, tailgate, timer_done, inc_req, dec_req;

  assign pin_ok     = try_pin && (pin == PASSWORD);
  assign pin_bad    = try_pin && (pin != PASSWORD);
  assign tailgate   = car_arrive && car_passed;
  assign timer_done = (timer == TW'(TIMEOUT - 1));
  assign lot_full   = (occupancy == OW'(CAPACITY));

  // Both sensors high together means a tailgate or a blocked gate; it wins
  // over every other event outside BLOCK, so a passing car is not counted.
  assign inc_req = (state == OPEN) && car_passed && !car_arrive;
  assign dec_req = car_exit;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tries       <= '0;
      timer       <= '0;
      occupancy   <= '0;
      open_gate   <= 1'b0;
      close_gate  <= 1'b0;
      alarm_pin   <= 1'b0;
      alarm_block <= 1'b0;
    end else begin
      state       <= state_next;
      tries       <= tries_next;
      timer       <= timer_next;
      occupancy   <= occupancy_next;
      open_gate   <= open_gate_next;
      close_gate  <= close_gate_next;
      alarm_pin   <= alarm_pin_next;
      alarm_block <= alarm_block_next;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (tailgate)                     state_next = BLOCK;
        else if (car_arrive && !lot_full) state_next = PIN;
        else                              state_next = IDLE;
      end
      PIN: begin
        if (tailgate)    state_next = BLOCK;
        else if (pin_ok) state_next = OPEN;
        else             state_next = PIN;
      end
      OPEN: begin
        if (tailgate)                      state_next = BLOCK;
        else if (car_passed || timer_done) state_next = IDLE;
        else                               state_next = OPEN;
      end
      BLOCK: begin
        if (pin_ok) state_next = IDLE;
        else        state_next = BLOCK;
      end
      default: state_next = IDLE;
    endcase
  end

  // Next values of counters and gate/alarm outputs
  always_comb begin
    tries_next       = tries;
    timer_next       = timer;
    open_gate_next   = open_gate;
    close_gate_next  = close_gate;
    alarm_pin_next   = alarm_pin;
    alarm_block_next = alarm_block;
    occupancy_next   = occupancy;

    case (state)
      IDLE, PIN, OPEN: begin
        if (tailgate) begin
          alarm_block_next = 1'b1;
          open_gate_next   = 1'b0;
          close_gate_next  = 1'b1;
        end else if (state == PIN) begin
          if (pin_ok) begin
            open_gate_next  = 1'b1;
            close_gate_next = 1'b0;
            tries_next      = '0;
            alarm_pin_next  = 1'b0;
            timer_next      = '0;
          end else if (pin_bad) begin
            if (tries < NW'(MAX_TRIES)) begin
              tries_next = tries + NW'(1);
            end else begin
              tries_next = tries;
            end
            if (tries_next == NW'(MAX_TRIES)) begin
              alarm_pin_next = 1'b1;
            end else begin
              alarm_pin_next = alarm_pin;
            end
          end else begin
            tries_next = tries;
          end
        end else if (state == OPEN) begin
          if (car_passed || timer_done) begin
            open_gate_next  = 1'b0;
            close_gate_next = 1'b1;
          end else begin
            timer_next = timer + TW'(1);
          end
        end else begin
          timer_next = timer;
        end
      end
      BLOCK: begin
        if (pin_ok) begin
          alarm_block_next = 1'b0;
          alarm_pin_next   = 1'b0;
          tries_next       = '0;
        end else begin
          tries_next = tries;
        end
      end
      default: begin
        tries_next = tries;
      end
    endcase

    // A simultaneous entry and exit cancel out
    if (inc_req && dec_req) begin
      occupancy_next = occupancy;
    end else if (inc_req && (occupancy < OW'(CAPACITY))) begin
      occupancy_next = occupancy + OW'(1);
    end else if (dec_req && (occupancy != '0)) begin
      occupancy_next = occupancy - OW'(1);
    end else begin
      occupancy_next = occupancy;
    end
  end

endmodule

// File: tb/tb_parking_access_ctrl.sv
// Directed self-checking bench for parking_access_ctrl with a small lot
// (CAPACITY=2) and a short entry window (TIMEOUT=4).
module tb_parking_access_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       car_arrive = 1'b0;
  logic       car_passed = 1'b0;
  logic       car_exit = 1'b0;
  logic       try_pin = 1'b0;
  logic [7:0] pin = 8'd0;
  logic       open_gate, close_gate, alarm_pin, alarm_block, lot_full;
  logic [1:0] occupancy;

  int checks = 0;
  int errors = 0;

  parking_access_ctrl #(
    .PW(8), .PASSWORD(8'd87), .MAX_TRIES(3), .CAPACITY(2), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .car_arrive(car_arrive), .car_passed(car_passed), .car_exit(car_exit),
    .try_pin(try_pin), .pin(pin),
    .open_gate(open_gate), .close_gate(close_gate),
    .alarm_pin(alarm_pin), .alarm_block(alarm_block),
    .lot_full(lot_full), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pin_try(input logic [7:0] value);
    try_pin = 1'b1;
    pin     = value;
    step();
    try_pin = 1'b0;
  endtask

  // IDLE -> PIN -> OPEN -> car passes, with an optional exit pulse on the pass cycle
  task automatic admit(input logic with_exit);
    car_arrive = 1'b1;
    step();
    car_arrive = 1'b0;
    pin_try(8'd87);
    car_passed = 1'b1;
    car_exit   = with_exit;
    step();
    car_passed = 1'b0;
    car_exit   = 1'b0;
  endtask

  initial begin
    step();
    step();
    check_eq("rst_open", open_gate, 0);
    check_eq("rst_close", close_gate, 0);
    check_eq("rst_alarm_pin", alarm_pin, 0);
    check_eq("rst_alarm_block", alarm_block, 0);
    check_eq("rst_occ", occupancy, 0);
    check_eq("rst_full", lot_full, 0);
    rst = 1'b0;

    // Basic entry
    car_arrive = 1'b1;
    step();
    check_eq("pin_state_open", open_gate, 0);
    pin_try(8'd87);
    check_eq("entry_open", open_gate, 1);
    check_eq("entry_close", close_gate, 0);
    car_arrive = 1'b0;
    car_passed = 1'b1;
    step();
    car_passed = 1'b0;
    check_eq("passed_open", open_gate, 0);
    check_eq("passed_close", close_gate, 1);
    check_eq("passed_occ", occupancy, 1);

    // Wrong PINs then correct, then timeout with no car
    car_arrive = 1'b1;
    step();
    car_arrive = 1'b0;
    pin_try(8'd12);
    check_eq("wrong1_alarm", alarm_pin, 0);
    pin_try(8'd12);
    check_eq("wrong2_alarm", alarm_pin, 0);
    pin_try(8'd12);
    check_eq("wrong3_alarm", alarm_pin, 1);
    pin_try(8'd12);
    check_eq("wrong4_alarm_held", alarm_pin, 1);
    pin_try(8'd87);
    check_eq("recover_alarm", alarm_pin, 0);
    check_eq("recover_open", open_gate, 1);
    step();
    step();
    step();
    check_eq("timeout_cycle3_open", open_gate, 1);
    step();
    check_eq("timeout_cycle4_open", open_gate, 0);
    check_eq("timeout_close", close_gate, 1);
    check_eq("timeout_occ", occupancy, 1);

    // Tailgate in OPEN
    car_arrive = 1'b1;
    step();
    car_arrive = 1'b0;
    pin_try(8'd87);
    check_eq("blk_pre_open", open_gate, 1);
    car_arrive = 1'b1;
    car_passed = 1'b1;
    step();
    car_arrive = 1'b0;
    car_passed = 1'b0;
    check_eq("blk_alarm", alarm_block, 1);
    check_eq("blk_open", open_gate, 0);
    check_eq("blk_close", close_gate, 1);
    check_eq("blk_occ", occupancy, 1);
    pin_try(8'd12);
    check_eq("blk_wrong_alarm", alarm_block, 1);
    check_eq("blk_wrong_pin_alarm", alarm_pin, 0);
    pin_try(8'd87);
    check_eq("blk_clear", alarm_block, 0);
    check_eq("blk_clear_open", open_gate, 0);

    // Fill the lot, then refused entry
    admit(1'b0);
    check_eq("full_occ", occupancy, 2);
    check_eq("full_flag", lot_full, 1);
    car_arrive = 1'b1;
    step();
    car_arrive = 1'b0;
    pin_try(8'd87);
    check_eq("full_refused_open", open_gate, 0);

    // Exits and saturation at zero
    car_exit = 1'b1;
    step();
    check_eq("exit1_occ", occupancy, 1);
    check_eq("exit1_full", lot_full, 0);
    step();
    check_eq("exit2_occ", occupancy, 0);
    step();
    car_exit = 1'b0;
    check_eq("exit_sat_occ", occupancy, 0);

    // Entry and exit on the same cycle cancel
    admit(1'b1);
    check_eq("inc_dec_occ", occupancy, 0);
    admit(1'b0);
    check_eq("readmit_occ", occupancy, 1);

    // Reset while the gate is open
    car_arrive = 1'b1;
    step();
    car_arrive = 1'b0;
    pin_try(8'd87);
    check_eq("pre_rst_open", open_gate, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mid_rst_open", open_gate, 0);
    check_eq("mid_rst_close", close_gate, 0);
    check_eq("mid_rst_alarm_pin", alarm_pin, 0);
    check_eq("mid_rst_alarm_block", alarm_block, 0);
    check_eq("mid_rst_occ", occupancy, 0);
    step();
    check_eq("post_rst_idle_open", open_gate, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
